jtag_reset_sequencer: RTL
=========================

# jtag_reset_sequencer

Owns the active-low JTAG reset line and shares it between three requesters: the idle watchdog, host software and an external pin. It first generates a power-on reset pulse. After that, a fixed-priority arbiter grants one request at a time and sequences the line through four phases: assert for a fixed width, settle, report completion, then a cooldown that blocks reset storms. It sits between the idle-timeout logic and the JTAG converter core, replacing direct drive of the converter's reset input.

## Interface
- PULSE_CYCLES, 250: cycles RESET_JTAG_N is held low per reset (10 µs at 25 MHz); legal ≥1.
- SETTLE_CYCLES, 2500: cycles after release before completion is reported; legal ≥1.
- COOLDOWN_CYCLES, 25000: cycles after completion during which no request is granted; legal ≥1.
- CNT_W, 8: width of RESET_COUNT.

Ports:
- CLK  in  1  system clock, external 24/25 MHz oscillator.
- nRST_ASYNC  in  1  reset, asynchronous, active-low.
- REQ  in  3  level requests, held until ACK; bit0 = watchdog, bit1 = host, bit2 = external.
- ACK  out  3  one-cycle grant pulse, one-hot.
- DONE  out  3  one-cycle completion pulse to the granted requester.
- RESET_JTAG_N  out  1  active-low reset to the JTAG core.
- READY  out  1  high only in IDLE.
- GRANT_ID  out  2  index of the last granted requester.
- RESET_COUNT  out  CNT_W  saturating count of granted resets.

## Operation
States: POR → SETTLE_POR → IDLE → ASSERT → SETTLE → COOLDOWN → IDLE.

- **Counter:** one shared down-counter, sized for the maximum of the three parameters. It is loaded (N−1) on entry to a state; the state exits when the counter is 0 and the counter is decremented.
- **POR:**
  - RESET_JTAG_N=0 for PULSE_CYCLES, then SETTLE_POR for SETTLE_CYCLES, then IDLE.
  - No ACK, no DONE, no count increment, no cooldown.
- **IDLE with any REQ bit high:**
  - The lowest set index wins.
  - ACK[i]=1 for one cycle. GRANT_ID←i.
  - RESET_COUNT increments, saturating at all-ones.
  - Next state is ASSERT.
- **ASSERT:** RESET_JTAG_N=0.
- **SETTLE:** RESET_JTAG_N=1. On exit, DONE[GRANT_ID]=1 for one cycle, then COOLDOWN.
- **COOLDOWN:** on expiry, go to IDLE.
- **REQ outside IDLE:** ignored, not latched. A requester still high when IDLE is re-entered is arbitrated then.
- **REQ dropped before ACK:** withdrawn; no action.
- **Simultaneous REQ:** fixed priority (0 > 1 > 2). Losers are served after the cooldown if still asserted. Starvation of bit2 is accepted.
- **Async reset in any state:**
  - Immediate return to POR with RESET_JTAG_N=0.
  - ACK and DONE are cleared; RESET_COUNT and GRANT_ID are cleared.
  - An in-flight grant receives no DONE.

## Timing
- **Registration:** all outputs are registered. Reset values: RESET_JTAG_N=0, READY=0, ACK=0, DONE=0, GRANT_ID=0, RESET_COUNT=0.
- **POR release:**
  - RESET_JTAG_N stays low for exactly PULSE_CYCLES rising edges after nRST_ASYNC deasserts.
  - READY rises SETTLE_CYCLES cycles after RESET_JTAG_N rises.
- **Grant:** REQ[i] sampled high at edge t in IDLE gives, at edge t:
  - ACK[i]=1;
  - RESET_JTAG_N=0;
  - READY=0.
- **ACK duration:** ACK is low again from t+1.
- **Pulse and settle:** RESET_JTAG_N is low on edges t..t+PULSE_CYCLES−1 and high from t+PULSE_CYCLES.
- **Completion:** DONE[i] is high during the cycle starting at edge t+PULSE_CYCLES+SETTLE_CYCLES.
- **Return to IDLE:** READY=1 from edge t+PULSE_CYCLES+SETTLE_CYCLES+COOLDOWN_CYCLES.
- **Back-to-back requests:** a request still held then is granted at that same edge. Minimum grant spacing = PULSE+SETTLE+COOLDOWN cycles.
- **Invariants:** ACK and DONE never coincide, and at most one bit of each is high.

## Structure
- Package jtag_rst_seq_pkg:
  - state enum;
  - requester index constants REQ_WDT=0, REQ_HOST=1, REQ_EXT=2;
  - N_REQ=3.
- Sub-module jtag_rst_prio_arb: fixed-priority encoder (REQ → valid, one-hot, index). It is combinational and instantiated once.
- The FSM, shared counter and outputs live in the top module.

## Test plan
Bench parameters: PULSE=4, SETTLE=3, COOLDOWN=5, CNT_W=2.

- **POR:** release reset → RESET_JTAG_N low for 4 cycles, high; READY=1 3 cycles later; ACK/DONE never pulse; RESET_COUNT=0.
- **Single host request:** REQ=3'b010 in IDLE → ACK=3'b010 for 1 cycle, RESET_JTAG_N low 4 cycles, DONE=3'b010 at offset 7, READY at offset 12, GRANT_ID=1, RESET_COUNT=1.
- **Simultaneous requests:**
  - REQ=3'b110 held → ACK=3'b010 first.
  - Then ACK=3'b100 exactly 12 cycles after the first ACK.
  - Bit2 DONE follows 7 cycles later.
- **REQ during ASSERT:** REQ[0] pulsed for 1 cycle during ASSERT → never acknowledged.
- **Saturation:** five grants → RESET_COUNT saturates at 2'b11.
- **Reset mid-SETTLE:** nRST_ASYNC low mid-SETTLE → RESET_JTAG_N=0 immediately, no DONE, RESET_COUNT=0, and the POR sequence repeats.

Source files
------------

// File: rtl/jtag_rst_seq_pkg.sv
//------------------------------------------------------------------------------
// jtag_rst_seq_pkg
//
// Shared definitions for the JTAG reset sequencer: sequencer states, the
// requester index map and a small helper to size the shared phase counter.
//------------------------------------------------------------------------------
package jtag_rst_seq_pkg;

  // Number of reset requesters sharing the JTAG reset line.
  localparam int N_REQ = 3;

  // Requester indices. A lower index means a higher arbitration priority.
  localparam int REQ_WDT  = 0;  // idle watchdog
  localparam int REQ_HOST = 1;  // host software
  localparam int REQ_EXT  = 2;  // external pin

  // Sequencer states. POR and SETTLE_POR run once after nRST_ASYNC releases.
  // Every granted reset then runs ASSERT -> SETTLE -> COOLDOWN.
  typedef enum logic [2:0] {
    ST_POR        = 3'd0,
    ST_SETTLE_POR = 3'd1,
    ST_IDLE       = 3'd2,
    ST_ASSERT     = 3'd3,
    ST_SETTLE     = 3'd4,
    ST_COOLDOWN   = 3'd5
  } state_e;

  // Largest of three phase lengths. It sizes the single shared down-counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/jtag_rst_prio_arb.sv
//------------------------------------------------------------------------------
// jtag_rst_prio_arb
//
// Combinational fixed-priority encoder for the reset requesters.
// Bit 0 has the highest priority and bit N_REQ-1 the lowest. Starvation of
// the low-priority requesters is accepted by design.
//
// Ports:
//   req          in   N_REQ  level requests
//   valid        out  1      at least one request is present
//   grant_onehot out  N_REQ  one-hot mask of the winning requester
//   grant_idx    out  2      index of the winning requester
//------------------------------------------------------------------------------
module jtag_rst_prio_arb
  import jtag_rst_seq_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  output logic             valid,
  output logic [N_REQ-1:0] grant_onehot,
  output logic [1:0]       grant_idx
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, so that no path can infer a latch.
  always_comb begin
    valid        = 1'b0;
    grant_onehot = '0;
    grant_idx    = '0;
    // Scan from the lowest priority upward. The last hit is the
    // highest-priority set bit, so it overrides the earlier ones.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid           = 1'b1;
        grant_onehot    = '0;
        grant_onehot[i] = 1'b1;
        grant_idx       = 2'(i);
      end
    end
  end

endmodule

// File: rtl/jtag_reset_sequencer.sv
//------------------------------------------------------------------------------
// jtag_reset_sequencer
//
// Owns the active-low JTAG reset line. The watchdog, the host and an external
// pin share it. After nRST_ASYNC releases, the block first issues a power-on
// reset pulse and a settle period. It then grants one request at a time by
// fixed priority and runs the line through four phases: assert for
// PULSE_CYCLES, settle for SETTLE_CYCLES, report DONE, then block new grants
// for COOLDOWN_CYCLES.
//
// Parameters:
//   PULSE_CYCLES    cycles RESET_JTAG_N is held low per reset (>=1)
//   SETTLE_CYCLES   cycles after release before completion is reported (>=1)
//   COOLDOWN_CYCLES cycles after completion with no new grant (>=1)
//   CNT_W           width of RESET_COUNT
//
// Ports:
//   CLK          in   1      system clock
//   nRST_ASYNC   in   1      asynchronous active-low reset
//   REQ          in   3      level requests, held until ACK (0=wdt,1=host,2=ext)
//   ACK          out  3      one-cycle one-hot grant pulse
//   DONE         out  3      one-cycle completion pulse to the granted requester
//   RESET_JTAG_N out  1      active-low reset to the JTAG core
//   READY        out  1      high only in IDLE
//   GRANT_ID     out  2      index of the last granted requester
//   RESET_COUNT  out  CNT_W  saturating count of granted resets
//
// All outputs are registered.
//------------------------------------------------------------------------------
module jtag_reset_sequencer
  import jtag_rst_seq_pkg::*;
#(
  parameter int PULSE_CYCLES    = 250,
  parameter int SETTLE_CYCLES   = 2500,
  parameter int COOLDOWN_CYCLES = 25000,
  parameter int CNT_W           = 8
) (
  input  logic             CLK,
  input  logic             nRST_ASYNC,
  input  logic [N_REQ-1:0] REQ,
  output logic [N_REQ-1:0] ACK,
  output logic [N_REQ-1:0] DONE,
  output logic             RESET_JTAG_N,
  output logic             READY,
  output logic [1:0]       GRANT_ID,
  output logic [CNT_W-1:0] RESET_COUNT
);

  // The shared counter only ever holds a load value of N-1, so
  // clog2(max N) bits are enough. The width is at least one bit.
  localparam int TMR_MAX = max3(PULSE_CYCLES, SETTLE_CYCLES, COOLDOWN_CYCLES);
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] PULSE_LOAD    = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD   = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] COOLDOWN_LOAD = TMR_W'(COOLDOWN_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE       = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  // State and registered outputs.
  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               rst_jtag_n_q, rst_jtag_n_d;
  logic               ready_q, ready_d;
  logic [1:0]         grant_id_q, grant_id_d;
  logic [CNT_W-1:0]   reset_count_q, reset_count_d;

  // Arbiter results.
  logic               arb_valid;
  logic [N_REQ-1:0]   arb_onehot;
  logic [1:0]         arb_idx;

  logic               tmr_expired;
  logic               take_grant;

  jtag_rst_prio_arb u_arb (
    .req          (REQ),
    .valid        (arb_valid),
    .grant_onehot (arb_onehot),
    .grant_idx    (arb_idx)
  );

  assign tmr_expired = (tmr_q == '0);

  //----------------------------------------------------------------------------
  // Next-state and next-output logic
  //----------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    tmr_d         = tmr_expired ? tmr_q : (tmr_q - TMR_ONE);
    ack_d         = '0;
    done_d        = '0;
    grant_id_d    = grant_id_q;
    reset_count_d = reset_count_q;
    take_grant    = 1'b0;

    case (state_q)
      ST_POR: begin
        if (tmr_expired) begin
          state_d = ST_SETTLE_POR;
          tmr_d   = SETTLE_LOAD;
        end
      end

      // The power-on sequence has no cooldown. It goes straight to IDLE.
      ST_SETTLE_POR: begin
        if (tmr_expired) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        take_grant = arb_valid;
      end

      ST_ASSERT: begin
        if (tmr_expired) begin
          state_d = ST_SETTLE;
          tmr_d   = SETTLE_LOAD;
        end
      end

      ST_SETTLE: begin
        if (tmr_expired) begin
          state_d = ST_COOLDOWN;
          tmr_d   = COOLDOWN_LOAD;
          for (int i = 0; i < N_REQ; i++) begin
            done_d[i] = (grant_id_q == 2'(i));
          end
        end
      end

      // A request still held at cooldown expiry is granted on that same
      // edge. This keeps back-to-back grants exactly PULSE+SETTLE+COOLDOWN
      // cycles apart, without a dead IDLE cycle between them.
      ST_COOLDOWN: begin
        if (tmr_expired) begin
          if (arb_valid) begin
            take_grant = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_POR;
        tmr_d   = PULSE_LOAD;
      end
    endcase

    if (take_grant) begin
      state_d    = ST_ASSERT;
      tmr_d      = PULSE_LOAD;
      ack_d      = arb_onehot;
      grant_id_d = arb_idx;
      if (reset_count_q != '1) begin
        reset_count_d = reset_count_q + CNT_ONE;
      end
    end

    // The line and READY depend only on the state being entered. Each
    // register then changes on the same edge as the state.
    rst_jtag_n_d = !((state_d == ST_POR) || (state_d == ST_ASSERT));
    ready_d      = (state_d == ST_IDLE);
  end

  //----------------------------------------------------------------------------
  // State and output registers
  //----------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together from the values sampled before the clock edge.
  always_ff @(posedge CLK or negedge nRST_ASYNC) begin
    if (!nRST_ASYNC) begin
      state_q       <= ST_POR;
      tmr_q         <= PULSE_LOAD;
      ack_q         <= '0;
      done_q        <= '0;
      rst_jtag_n_q  <= 1'b0;
      ready_q       <= 1'b0;
      grant_id_q    <= '0;
      reset_count_q <= '0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      ack_q         <= ack_d;
      done_q        <= done_d;
      rst_jtag_n_q  <= rst_jtag_n_d;
      ready_q       <= ready_d;
      grant_id_q    <= grant_id_d;
      reset_count_q <= reset_count_d;
    end
  end

  assign ACK          = ack_q;
  assign DONE         = done_q;
  assign RESET_JTAG_N = rst_jtag_n_q;
  assign READY        = ready_q;
  assign GRANT_ID     = grant_id_q;
  assign RESET_COUNT  = reset_count_q;

endmodule
